lifo_arbiter: RTL
=================

Name: lifo_arbiter

Overview:
- Shares one single-port LIFO stack (4-bit data, EN/RW/FULL/EMPTY interface) between NREQ requesters.
- Each requester issues push or pop transactions; the block arbitrates round-robin and sequences the LIFO's EN/RW/data strobes.
- Returns pop data and per-transaction status to the requester it granted.
- Sits between client logic and the LIFO instance; it is the LIFO's only driver.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 4, data width; matches the LIFO data width.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  reset, synchronous, active-low.
- req_valid  input  NREQ  per-requester request; held until granted.
- req_rw  input  NREQ  per-requester op: 0 = push, 1 = pop (LIFO RW encoding).
- req_data  input  NREQ*DW  push data; requester i occupies bits [i*DW +: DW].
- req_grant  output  NREQ  one-hot, one-cycle acceptance pulse.
- rsp_valid  output  NREQ  one-hot, one-cycle completion pulse to the owning requester.
- rsp_err  output  1  qualifies rsp_valid; 1 = rejected (push when full, pop when empty).
- rsp_data  output  DW  pop data; valid with rsp_valid when rsp_err = 0.
- lifo_en  output  1  to LIFO EN.
- lifo_rw  output  1  to LIFO RW.
- lifo_din  output  DW  to LIFO dataIn.
- lifo_dout  input  DW  from LIFO dataOut.
- lifo_full  input  1  from LIFO FULL.
- lifo_empty  input  1  from LIFO EMPTY.

Behaviour:
- LIFO contract:
  - EN = 1, RW = 0 at an edge pushes dataIn.
  - EN = 1, RW = 1 pops; dataOut is valid the cycle after the pop edge.
- All outputs are registered.
- Reset (Rst = 0 at an edge):
  - state = IDLE; rr_ptr = NREQ-1 (requester 0 has first priority).
  - All outputs 0.
  - Any in-flight transaction is abandoned with no response. The LIFO's own reset is separate.
- FSM states: IDLE, ISSUE, WAIT, RESP, REJECT.
- IDLE:
  - If any req_valid is set, pick winner w: the first set bit searching upward from rr_ptr+1, with wrap.
  - If (push & lifo_full) or (pop & lifo_empty), go to REJECT.
  - Otherwise go to ISSUE with lifo_en = 1, lifo_rw = req_rw[w], lifo_din = req_data[w].
  - rr_ptr <= w on every grant, including rejected ones.
- ISSUE (1 cycle): req_grant[w] = 1, lifo_en = 1. Push goes to RESP; pop goes to WAIT.
- WAIT (1 cycle): lifo_en = 0. At the exiting edge, rsp_data <= lifo_dout. Go to RESP.
- RESP (1 cycle): rsp_valid[w] = 1, rsp_err = 0. Go to IDLE.
- REJECT (1 cycle): req_grant[w] = 1, rsp_valid[w] = 1, rsp_err = 1. No LIFO access. Go to IDLE.
- Latency, counting from the edge that samples the request in IDLE:
  - Push: grant at +1, response at +2, next arbitration at +3.
  - Pop: grant at +1, response at +3, next arbitration at +4.
  - Reject: grant and response at +1, next arbitration at +2.
- Requesters may drop or change req_* in the cycle after req_grant. The block ignores req_* outside IDLE.
- lifo_full/lifo_empty are sampled only in IDLE. They are stable because this block is the sole driver.
- rsp_data holds its last pop value when not being updated.

Optional Feature:
- Macro: LIFO_ARB_ERRCNT_EN.
- With the macro defined:
  - Adds output err_count (8 bits, reset 0).
  - Increments on each REJECT and saturates at 255.
  - Adds input err_clr (1 bit); when high, err_count <= 0, and clear wins over a simultaneous increment.
- Without the macro: neither port exists and there is no counter logic.

Decomposition:
- Package lifo_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP, REJECT);
  - OP_PUSH = 1'b0, OP_POP = 1'b1;
  - ERRCNT_W = 8.
- One sub-module, rr_picker: combinational round-robin search.
  - Inputs: req_valid, rr_ptr.
  - Outputs: one-hot win, index, any.

Test Plan:
- Reset: hold Rst = 0 for 3 edges with req_valid = 2'b11 -> all outputs 0, no lifo_en.
- Push then pop: requester 0 pushes 4'h6 on an empty LIFO, then pops -> push response at +2 with rsp_err = 0; pop response at +3 with rsp_data = 4'h6, rsp_valid = 2'b01.
- Fairness: both requesters push continuously (0 sends 4'h2, 1 sends 4'h4) -> grants alternate 01, 10, 01…; LIFO receives 2, 4, 2, 4.
- Pop when empty: requester 1 pops on an empty LIFO -> REJECT, with req_grant = rsp_valid = 2'b10 in the same cycle, rsp_err = 1, lifo_en never high.
- Push when full: push until lifo_full = 1, then push again -> rsp_err = 1, LIFO untouched; a following pop returns the last successfully pushed value.
- Reset mid-pop: drop Rst in WAIT -> next cycle is IDLE, no rsp_valid; with LIFO_ARB_ERRCNT_EN, err_count returns to 0.

Source files
------------

// File: rtl/lifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lifo_arb_pkg
// Description : Shared types and constants for the LIFO arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lifo_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        RESP   = 3'd3,
        REJECT = 3'd4
    } state_t;

    // Operation encoding, identical to the LIFO RW pin
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    // Width of the optional rejection counter
    localparam int ERRCNT_W = 8;

    // Index width for n requesters, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin search. Returns the first active
//               request found scanning upward from rr_ptr+1 with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   index,
    output logic            any
);

    int w_slot;

    // Scan every slot once, starting just after the last winner
    always_comb begin
        win    = '0;
        index  = '0;
        any    = 1'b0;
        w_slot = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_slot = (int'(rr_ptr) + k) % NREQ;
            if (!any && req_valid[w_slot[IW-1:0]]) begin
                any                  = 1'b1;
                win[w_slot[IW-1:0]]  = 1'b1;
                index                = w_slot[IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lifo_arbiter
// Description : Round-robin arbiter sharing one single-port LIFO between
//               NREQ requesters. Sequences EN/RW/data strobes and returns
//               per-transaction status and pop data. All outputs registered.
//               Optional rejection counter enabled by LIFO_ARB_ERRCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = 4
) (
    input  logic                Clk,
    input  logic                Rst,
`ifdef LIFO_ARB_ERRCNT_EN
    input  logic                err_clr,
    output logic [ERRCNT_W-1:0] err_count,
`endif
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_rw,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     req_grant,
    output logic [NREQ-1:0]     rsp_valid,
    output logic                rsp_err,
    output logic [DW-1:0]       rsp_data,
    output logic                lifo_en,
    output logic                lifo_rw,
    output logic [DW-1:0]       lifo_din,
    input  logic [DW-1:0]       lifo_dout,
    input  logic                lifo_full,
    input  logic                lifo_empty
);

    localparam int            IW        = idx_w(NREQ);
    localparam logic [IW-1:0] c_RR_INIT = IW'(NREQ - 1);

    state_t            r_state, w_state_nxt;
    logic [IW-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [NREQ-1:0]   r_win, w_win_nxt;
    logic              r_op, w_op_nxt;

    logic [NREQ-1:0]   w_grant_nxt, w_rsp_valid_nxt;
    logic              w_rsp_err_nxt, w_en_nxt, w_rw_nxt;
    logic [DW-1:0]     w_rsp_data_nxt, w_din_nxt;

    logic [NREQ-1:0]   w_pick_win;
    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_any;
    logic              w_req_rw;
    logic [DW-1:0]     w_req_din;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .win       (w_pick_win),
        .index     (w_pick_idx),
        .any       (w_pick_any)
    );

    // Select the winning requester's operation and push data
    always_comb begin
        w_req_rw  = 1'b0;
        w_req_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_win[i]) begin
                w_req_rw  = req_rw[i];
                w_req_din = req_data[i*DW +: DW];
            end
        end
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next values of every registered output
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_win_nxt       = r_win;
        w_op_nxt        = r_op;
        w_grant_nxt     = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_data_nxt  = rsp_data;
        w_en_nxt        = 1'b0;
        w_rw_nxt        = lifo_rw;
        w_din_nxt       = lifo_din;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_win_nxt    = w_pick_win;
                    w_op_nxt     = w_req_rw;
                    w_rr_ptr_nxt = w_pick_idx;
                    w_grant_nxt  = w_pick_win;
                    // Flags are stable here: nobody else drives the LIFO
                    if ((w_req_rw == OP_PUSH && lifo_full) ||
                        (w_req_rw == OP_POP  && lifo_empty)) begin
                        w_state_nxt     = REJECT;
                        w_rsp_valid_nxt = w_pick_win;
                        w_rsp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ISSUE;
                        w_en_nxt    = 1'b1;
                        w_rw_nxt    = w_req_rw;
                        w_din_nxt   = w_req_din;
                    end
                end
            end
            ISSUE: begin
                if (r_op == OP_POP) begin
                    w_state_nxt = WAIT;
                end else begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = r_win;
                end
            end
            WAIT: begin
                // Pop data appears on dataOut the cycle after the pop edge
                w_state_nxt     = RESP;
                w_rsp_valid_nxt = r_win;
                w_rsp_data_nxt  = lifo_dout;
            end
            RESP:    w_state_nxt = IDLE;
            REJECT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered outputs and transaction context
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_rr_ptr  <= c_RR_INIT;
            r_win     <= '0;
            r_op      <= OP_PUSH;
            req_grant <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            lifo_en   <= 1'b0;
            lifo_rw   <= 1'b0;
            lifo_din  <= '0;
        end else begin
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_win     <= w_win_nxt;
            r_op      <= w_op_nxt;
            req_grant <= w_grant_nxt;
            rsp_valid <= w_rsp_valid_nxt;
            rsp_err   <= w_rsp_err_nxt;
            rsp_data  <= w_rsp_data_nxt;
            lifo_en   <= w_en_nxt;
            lifo_rw   <= w_rw_nxt;
            lifo_din  <= w_din_nxt;
        end
    end

`ifdef LIFO_ARB_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_err_count;

    // Saturating count of rejected transactions; clear has priority
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (r_state == REJECT && r_err_count != '1) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire
